// File: rtl/set_host_pkg.sv
// Shared types and constants for the set_host job dispatcher and its request FIFO.
package set_host_pkg;

    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 16;
    localparam int COORD_W        = 4;
    localparam int CNT_W          = 4;
    localparam int CENT_W         = 4 * COORD_W;
    localparam int RAD_W          = 2 * COORD_W;
    localparam int REQ_W          = CENT_W + RAD_W;
    localparam int TMO_W          = 5;
    localparam int JOBS_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [CENT_W-1:0] central;
        logic [RAD_W-1:0]  radius;
    } job_t;

endpackage

// File: rtl/set_host_fifo.sv
// Synchronous request FIFO; pointers carry an extra MSB so full and empty are distinguishable.
module set_host_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/set_host.sv
// Buffers circle-pair requests and feeds them one at a time to the intersection
// counter engine, returning its count (or a timeout error) on the response port.
module set_host
    import set_host_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CENT_W-1:0] req_central,
    input  logic [RAD_W-1:0]  req_radius,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CNT_W-1:0]  rsp_count,
    output logic              rsp_err,
    output logic              set_en,
    output logic [CENT_W-1:0] set_central,
    output logic [RAD_W-1:0]  set_radius,
    input  logic              set_busy,
    input  logic              set_valid,
    input  logic [CNT_W-1:0]  set_candidate,
    output logic [JOBS_W-1:0] jobs_done
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMO_W-1:0]   r_tmo;
    logic [CNT_W-1:0]   r_rsp_count;
    logic               r_rsp_err;
    logic [JOBS_W-1:0]  r_jobs;
    logic               r_busy_seen;

    job_t               w_wjob;
    job_t               w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_done;
    logic               w_tmo;
    logic               w_tmo_hit;
    logic               w_wait;
    logic               w_active;

    assign w_wjob = {req_central, req_radius};
    assign w_push = req_valid && req_ready;
    assign w_pop  = w_done || w_tmo;

    set_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wjob),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_wait    = (r_state == ST_WAIT_ACK) || (r_state == ST_WAIT_DONE);
    assign w_active  = (r_state == ST_ISSUE) || w_wait;
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

    // Completion wins over timeout when both land on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && set_valid && !rsp_valid) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (w_tmo_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (!set_valid) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (set_valid) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_RESP;
                end else if (w_tmo_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo       <= '0;
            r_rsp_count <= '0;
            r_rsp_err   <= 1'b0;
            r_jobs      <= '0;
            r_busy_seen <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_tmo       <= '0;
                r_busy_seen <= 1'b0;
            end else if (w_wait) begin
                r_tmo       <= r_tmo + 1'b1;
                r_busy_seen <= r_busy_seen | set_busy;
            end
            if (w_done) begin
                r_rsp_count <= set_candidate;
                r_rsp_err   <= 1'b0;
                r_jobs      <= r_jobs + 1'b1;
            end else if (w_tmo) begin
                r_rsp_count <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    // Operands are only presented while a job owns the engine.
    assign set_en      = (r_state == ST_ISSUE);
    assign set_central = w_active ? w_head.central : '0;
    assign set_radius  = w_active ? w_head.radius  : '0;
    assign req_ready   = !w_full;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_count   = r_rsp_count;
    assign rsp_err     = r_rsp_err;
    assign jobs_done   = r_jobs;

endmodule

// File: tb/tb_set_host.sv
// Scoreboard bench for set_host: directed requests, a behavioural counter engine and a response monitor.
module tb_set_host;

    typedef struct packed {
        logic [3:0] cnt;
        logic       err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_central = '0;
    logic [7:0]  req_radius = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_count;
    logic        rsp_err;
    logic        set_en;
    logic [15:0] set_central;
    logic [7:0]  set_radius;
    logic        set_busy = 1'b0;
    logic        set_valid = 1'b1;
    logic [3:0]  set_candidate = '0;
    logic [7:0]  jobs_done;

    int          n_vec = 0;
    int          n_bad = 0;
    rsp_t        exp_q[$];
    logic [23:0] op_q[$];
    rsp_t        mon_e;
    logic [7:0]  exp_jobs = '0;
    bit          in_job = 1'b0;
    bit          hang = 1'b0;
    bit          busy_noise = 1'b0;
    int          eng_cnt = 0;
    bit          eng_v = 1'b1;
    bit          eng_en = 1'b0;

    set_host #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_central   (req_central),
        .req_radius    (req_radius),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_count     (rsp_count),
        .rsp_err       (rsp_err),
        .set_en        (set_en),
        .set_central   (set_central),
        .set_radius    (set_radius),
        .set_busy      (set_busy),
        .set_valid     (set_valid),
        .set_candidate (set_candidate),
        .jobs_done     (jobs_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Engine: drops valid the cycle after set_en, re-raises it 7 cycles after set_en
    // with candidate = central[11:8] + radius[3:0]; hang freezes it in the busy phase.
    initial begin : engine
        forever begin
            @(negedge clk);
            eng_en = set_en;
            @(posedge clk);
            #1;
            if (rst) begin
                eng_v   = 1'b1;
                eng_cnt = 0;
            end else if (eng_en) begin
                eng_v   = 1'b0;
                eng_cnt = 6;
            end else if (!eng_v && !hang) begin
                if (eng_cnt <= 1) begin
                    eng_cnt       = 0;
                    eng_v         = 1'b1;
                    set_candidate = set_central[11:8] + set_radius[3:0];
                end else begin
                    eng_cnt--;
                end
            end
            set_valid = eng_v;
            set_busy  = !eng_v || busy_noise;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                op_q.delete();
                in_job   = 1'b0;
                exp_jobs = '0;
            end else begin
                if (set_en) begin
                    chk("single_issue", 32'(in_job), 32'd0);
                    in_job = 1'b1;
                end
                if (rsp_valid && in_job) begin
                    in_job = 1'b0;
                    if (op_q.size() != 0) void'(op_q.pop_front());
                end
                if (in_job) begin
                    if (op_q.size() != 0) chk("operands_hold", 32'({set_central, set_radius}), 32'(op_q[0]));
                end else begin
                    chk("operands_zero", 32'({set_central, set_radius}), 32'd0);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_rsp: got count %0h err %0b, expected no response", rsp_count, rsp_err);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("rsp_count", 32'(rsp_count), 32'(mon_e.cnt));
                        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                        if (!mon_e.err) exp_jobs = exp_jobs + 8'd1;
                        chk("jobs_done", 32'(jobs_done), 32'(exp_jobs));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    // Call at posedge+1; returns at posedge+1 after the accept edge.
    task automatic push(input logic [15:0] c, input logic [7:0] r, input logic [3:0] ec, input logic ee);
        int w;
        w           = 0;
        req_valid   = 1'b1;
        req_central = c;
        req_radius  = r;
        @(negedge clk);
        while (!req_ready && w < 300) begin
            w++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_accept: req_ready still 0 after %0d cycles, expected 1", w);
        end else begin
            exp_q.push_back({ec, ee});
            op_q.push_back({c, r});
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int lim);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < lim) begin
            @(negedge clk);
            w++;
        end
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Counts negedges from call to set_en and to rsp_valid.
    task automatic measure(output int ken, output int krsp);
        int k;
        k    = 0;
        ken  = -1;
        krsp = -1;
        while (k < 60 && krsp < 0) begin
            @(negedge clk);
            k++;
            if (set_en && ken < 0) ken = k;
            if (rsp_valid) krsp = k;
        end
    endtask

    initial begin : stim
        int          ken;
        int          krsp;
        logic [15:0] c;
        logic [7:0]  r;
        logic [3:0]  e;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_set_en", 32'(set_en), 32'd0);
        chk("rst_rsp_count", 32'(rsp_count), 32'd0);
        chk("rst_jobs_done", 32'(jobs_done), 32'd0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single job with latency checks
        push(16'h3355, 8'h22, 4'h5, 1'b0);
        measure(ken, krsp);
        chk("accept_to_set_en", ken, 2);
        chk("set_en_to_rsp", krsp - ken, 8);
        wait_drain(50);

        // Back-pressure: five requests held behind a stalled response
        busy_noise = 1'b1;
        rsp_ready  = 1'b0;
        push(16'h1234, 8'h51, 4'h3, 1'b0);
        push(16'h0F00, 8'h01, 4'h0, 1'b0);
        push(16'hA7C3, 8'h94, 4'hB, 1'b0);
        push(16'h4862, 8'h3A, 4'h2, 1'b0);
        push(16'hFEDC, 8'hBA, 4'h8, 1'b0);
        @(negedge clk);
        chk("full_req_ready", 32'(req_ready), 32'd0);
        chk("held_rsp_valid", 32'(rsp_valid), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain(300);

        // Timeout, then a normal job afterwards
        hang = 1'b1;
        push(16'h2222, 8'h11, 4'h0, 1'b1);
        measure(ken, krsp);
        chk("timeout_latency", krsp - ken, 17);
        wait_drain(50);
        hang = 1'b0;
        push(16'h0300, 8'h04, 4'h7, 1'b0);
        wait_drain(100);

        // Reset during WAIT_DONE with three requests queued behind the active one
        push(16'h1111, 8'h11, 4'h2, 1'b0);
        push(16'h2222, 8'h22, 4'h4, 1'b0);
        push(16'h3333, 8'h33, 4'h6, 1'b0);
        push(16'h4444, 8'h44, 4'h8, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_set_en", 32'(set_en), 32'd0);
        chk("mid_rst_operands", 32'({set_central, set_radius}), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp", 32'({rsp_count, rsp_err}), 32'd0);
        chk("mid_rst_jobs_done", 32'(jobs_done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({rsp_valid, set_en}), 32'd0);
        end
        @(posedge clk);
        #1;

        // 256 completed jobs wrap the job counter
        for (int i = 0; i < 256; i++) begin
            c = 16'(i * 16'h1357);
            r = 8'(i * 8'h2B);
            e = c[11:8] + r[3:0];
            push(c, r, e, 1'b0);
        end
        wait_drain(300);
        chk("jobs_done_wrap", 32'(jobs_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/set_host.md
SET_HOST -- requirements
Module: set_host

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of buffered requests (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 16, cycles allowed from set_en to job completion.
REQ-003 Clock and reset: reset rst, asynchronous, active-high; clock clk.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  request offered.
REQ-007 req_ready  output  1  request FIFO not full.
REQ-008 req_central  input  16  {x1,y1,x2,y2}, 4 bits each, x1 in [15:12].
REQ-009 req_radius  input  8  {r1,r2}, r1 in [7:4].
REQ-010 rsp_valid  output  1  response held.
REQ-011 rsp_ready  input  1  response consumer ready.
REQ-012 rsp_count  output  4  intersection point count returned by counter engine.
REQ-013 rsp_err  output  1  job timed out; rsp_count is 0.
REQ-014 set_en  output  1  one-cycle job start to counter engine.
REQ-015 set_central  output  16  engine centre operands.
REQ-016 set_radius  output  8  engine radius operands.
REQ-017 set_busy  input  1  engine loading operands.
REQ-018 set_valid  input  1  engine idle / result available.
REQ-019 set_candidate  input  4  engine result.
REQ-020 jobs_done  output  8  completed-job counter, wraps 255->0.

Function
REQ-021 Request accepted on a rising clk edge where req_valid and req_ready are both 1; {req_central,req_radius} pushed into the FIFO.
REQ-022 req_ready SHALL be 0 exactly when FIFO holds FIFO_DEPTH entries; a push and a pop in the same cycle on a full FIFO are not both permitted (req_ready low blocks the push).
REQ-023 FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP; reset state IDLE.
REQ-024 IDLE -> ISSUE when FIFO non-empty, set_valid=1 and rsp_valid=0; otherwise stay.
REQ-025 ISSUE lasts exactly one cycle: set_en=1; -> WAIT_ACK.
REQ-026 WAIT_ACK -> WAIT_DONE on first cycle set_valid=0.
REQ-027 WAIT_DONE -> RESP on first cycle set_valid=1; that cycle set_candidate is registered into rsp_count, rsp_err<=0, FIFO popped, jobs_done incremented.
REQ-028 Timeout: 5-bit counter cleared in ISSUE, incremented in WAIT_ACK/WAIT_DONE; on reaching TIMEOUT before completion -> RESP with rsp_count=0, rsp_err=1, FIFO popped, jobs_done not incremented.
REQ-029 RESP: rsp_valid=1, rsp_count/rsp_err stable until rsp_valid&rsp_ready edge; then -> IDLE, rsp_valid=0 next cycle.
REQ-030 set_central/set_radius SHALL equal the FIFO head from ISSUE through completion cycle inclusive; 0 in IDLE and RESP.
REQ-031 set_en SHALL be 0 in all states except ISSUE; never two set_en pulses without an intervening completion or timeout.
REQ-032 Latency with engine returning set_valid 7 cycles after set_en: rsp_valid rises 8 cycles after set_en cycle; request into empty idle block: set_en 2 cycles after accept edge.
REQ-033 busy input is monitor-only: set_busy=1 seen outside WAIT_ACK/WAIT_DONE is ignored.

Reset
REQ-034 rst asserted at any time: state IDLE, FIFO emptied, req_ready=1, set_en=0, set_central=0, set_radius=0, rsp_valid=0, rsp_count=0, rsp_err=0, jobs_done=0, timeout counter 0; in-flight job discarded, no response.

Structure
REQ-035 Package set_host_pkg holds state enum, default FIFO_DEPTH, default TIMEOUT, field widths (COORD_W=4, CNT_W=4).
REQ-036 One sub-module set_host_fifo: synchronous 24-bit FIFO, FIFO_DEPTH entries, full/empty flags, wrap-around pointers with extra MSB.

Verification
REQ-037 Single job: push 16'h3355/8'h22, engine model returns valid 7 cycles after en with candidate 4'h5 -> rsp_count=5, rsp_err=0, rsp_valid 8 cycles after set_en, jobs_done=1.
REQ-038 Back-pressure: push 5 requests with rsp_ready=0 -> req_ready=0 after 4 buffered plus first in flight completes; release rsp_ready -> 5 responses in order, jobs_done=5.
REQ-039 Timeout: engine model never re-asserts set_valid -> after 16 cycles rsp_err=1, rsp_count=0, jobs_done unchanged, next job issues normally.
REQ-040 Operand hold: check set_central/set_radius constant from set_en through completion cycle, 0 in IDLE.
REQ-041 Reset mid-job: assert rst during WAIT_DONE with 3 queued -> all outputs at reset values, no rsp_valid after release until new request.
REQ-042 Counter wrap: 256 completed jobs -> jobs_done reads 0.
